mac_vec_pe: RTL
===============

MAC_VEC_PE -- requirements
Module: mac_vec_pe

Interface
REQ-001 Parameter DATA_WIDTH, default 8, signed operand width per lane.
REQ-002 Parameter ACC_WIDTH, default 32, signed accumulator/result width; legal only if ACC_WIDTH >= 2*DATA_WIDTH + clog2(LANES) + 1.
REQ-003 Parameter LANES, default 4, number of parallel multiplier lanes; legal range 1..16.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_last  input  1  beat closes the current accumulation group.
REQ-009 in_a  input  LANES*DATA_WIDTH  signed activations; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_w  input  LANES*DATA_WIDTH  signed weights; same packing as in_a.
REQ-011 out_valid  output  1  group result held on out_acc.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_acc  output  ACC_WIDTH  signed group result.
REQ-014 out_sat  output  1  saturation occurred in this group.

Function
REQ-015 A beat is accepted when in_valid && in_ready; a cycle with in_valid=0 is a bubble and changes no accumulator state.
REQ-016 Stage 1 shall register all LANES signed products (2*DATA_WIDTH each), in_last, and a valid bit for each accepted beat.
REQ-017 Stage 2 shall sign-extend the products, sum them, and add the sum to the running accumulator.
REQ-018 When the stage-2 beat has last=1, stage 2 shall load accumulator+sum into out_acc, set out_valid, and clear the running accumulator to 0 for the next group.
REQ-019 Latency: a last beat accepted in cycle t shall produce out_valid=1 in cycle t+2.
REQ-020 A new group may begin on the beat immediately after a last beat, with no bubble.
REQ-021 in_ready = !out_valid || out_ready.
REQ-022 While out_valid && !out_ready, both stages and the accumulator shall hold, and out_acc/out_sat shall stay stable.
REQ-023 out_valid clears after an out_ready handshake unless a new result is loaded in the same cycle; a new result then replaces the old one with out_valid held at 1.
REQ-024 Without saturation, accumulation wraps modulo 2^ACC_WIDTH (two's complement).

Reset
REQ-025 While reset=1: out_valid=0, out_acc=0, out_sat=0, running accumulator=0, stage-1 valid=0, in_ready=0.
REQ-026 in_ready shall be 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-group discards the partial sum and any in-flight beats; no result is emitted for that group.

Configuration
REQ-028 Macro MAC_VEC_PE_SAT_EN defined: accumulator+sum is computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; accumulation continues from the clamped value.
REQ-029 With MAC_VEC_PE_SAT_EN defined, a sticky group flag sets on any clamp, is copied to out_sat with the result, and clears with the accumulator.
REQ-030 MAC_VEC_PE_SAT_EN undefined: wrap per REQ-024; out_sat tied to 0; no clamp logic present.

Verification (LANES=4, DATA_WIDTH=8, ACC_WIDTH=32 unless stated)
REQ-031 Single last beat a={1,2,3,4}, w={5,6,7,8} -> out_acc=70, out_valid exactly 2 cycles after acceptance.
REQ-032 One last beat with all a=-128, all w=-128 -> out_acc=65536; then a 3-beat group a={1,1,1,1}, w={-1,-1,-1,-1} with last on beat 3 -> out_acc=-12, sent back-to-back with no bubble.
REQ-033 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_acc stable, no beat lost; after release the next group's sums are correct.
REQ-034 ACC_WIDTH=20; 9 beats all a=127, w=127, last on beat 9 -> -467932 with out_sat=0 without the macro; 524287 with out_sat=1 with MAC_VEC_PE_SAT_EN.
REQ-035 Two beats accepted, reset pulsed, then a single last beat a={1,0,0,0}, w={1,0,0,0} -> out_acc=1; no output for the aborted group.

Source files
------------

// File: rtl/mac_vec_pe.sv
// Two-stage vector multiply-accumulate PE: registered lane products, then a summing accumulator with a held result.
// Optional clamp-on-overflow accumulation with sticky flag: define MAC_VEC_PE_SAT_EN.
module mac_vec_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [LANES*DATA_WIDTH-1:0]   in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_WIDTH-1:0]   out_acc,
  output logic                          out_sat
);

  localparam int PW = 2 * DATA_WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; valid, once raised, holds with its payload stable until accepted.
  // The whole pipeline advances only when the output register can take a result.
  logic adv;
  assign in_ready = !reset && (!out_valid || out_ready);
  assign adv      = in_ready;

  logic signed [PW-1:0] lane_prod [LANES];
  logic signed [PW-1:0] s1_prod   [LANES];
  logic                 s1_valid;
  logic                 s1_last;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        load;

  // Operands are sign-extended to the product width, so the low PW bits of
  // the unsigned multiply equal the signed product.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_prod[i] = {{DATA_WIDTH{in_a[i*DATA_WIDTH+DATA_WIDTH-1]}}, in_a[i*DATA_WIDTH +: DATA_WIDTH]} *
                     {{DATA_WIDTH{in_w[i*DATA_WIDTH+DATA_WIDTH-1]}}, in_w[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + {{(ACC_WIDTH-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
    end
  end

  assign load = s1_valid && s1_last;

`ifdef MAC_VEC_PE_SAT_EN
  logic signed [ACC_WIDTH:0] wide;
  logic                      clamp;
  logic                      grp_sat;

  always_comb begin
    wide  = {acc[ACC_WIDTH-1], acc} + {sum[ACC_WIDTH-1], sum};
    clamp = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    if (!clamp)
      acc_next = wide[ACC_WIDTH-1:0];
    else if (wide[ACC_WIDTH])
      acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_sat <= 1'b0;
      out_sat <= 1'b0;
    end else if (adv && s1_valid) begin
      if (s1_last) begin
        out_sat <= grp_sat | clamp;
        grp_sat <= 1'b0;
      end else begin
        grp_sat <= grp_sat | clamp;
      end
    end
  end
`else
  always_comb acc_next = acc + sum;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      acc       <= '0;
      out_acc   <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= lane_prod[i];
      end
      if (s1_valid) acc <= s1_last ? '0 : acc_next;
      // A new result may replace the one being handed off in the same cycle.
      if (load) begin
        out_acc   <= acc_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
